// File: rtl/fp_mul_pkg.sv
// Shared definitions for the floating-point multiplier back end.
// Holds the format widths, the canonical quiet NaN and the payload that the
// normalize stage hands to the round/pack stage.
package fp_mul_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int PROD_W = 2 * (FRAC_W + 1);
  localparam int RES_W  = EXP_W + FRAC_W + 1;
  // Working exponent: two extra bits so ea+eb-BIAS and its +1/+2 adjustments
  // never wrap.
  localparam int XEXP_W = EXP_W + 2;

  localparam logic [RES_W-1:0] QNAN = 32'h7FC0_0000;

  // Largest biased exponent is reserved for inf/NaN, so 2*BIAS+1 already overflows.
  localparam logic signed [XEXP_W-1:0] EXP_MAX  = XEXP_W'(2 * BIAS + 1);
  localparam logic signed [XEXP_W-1:0] EXP_ZERO = '0;
  localparam logic signed [XEXP_W-1:0] EXP_ONE  = XEXP_W'(1);

  typedef struct packed {
    logic                     sign;
    logic signed [XEXP_W-1:0] exp;
    logic [FRAC_W:0]          mant;
    logic                     guard;
    logic                     sticky;
    logic                     is_nan;
    logic                     is_inf;
    logic                     is_zero;
  } s1_pay_t;

endpackage

// File: rtl/fp_mul_norm_round_rne.sv
// Round-to-nearest-even incrementer.
// Ports:
//   mant_i   normalized significand including the hidden one
//   guard_i  first bit below the LSB
//   sticky_i OR of all remaining discarded bits
//   exp_i    working exponent before rounding
//   frac_o   rounded stored fraction (hidden one dropped)
//   exp_o    exponent after a possible rounding carry-out
module fp_round_ne
  import fp_mul_pkg::*;
(
  input  logic                     [FRAC_W:0] mant_i,
  input  logic                                guard_i,
  input  logic                                sticky_i,
  input  logic signed [XEXP_W-1:0]            exp_i,
  output logic                     [FRAC_W-1:0] frac_o,
  output logic signed [XEXP_W-1:0]            exp_o
);

  logic              inc;
  logic [FRAC_W+1:0] sum;
  logic              unused_lead;

  // Round up above the halfway point, or exactly at it when the LSB is odd.
  assign inc = guard_i & (sticky_i | mant_i[0]);
  assign sum = {1'b0, mant_i} + {{(FRAC_W + 1){1'b0}}, inc};

  // A carry-out only happens from an all-ones significand, leaving the sum at
  // exactly 2^(FRAC_W+1): the low bits are already the zero fraction we want.
  assign frac_o      = sum[FRAC_W-1:0];
  assign exp_o       = exp_i + $signed({{(XEXP_W - 1){1'b0}}, sum[FRAC_W+1]});
  assign unused_lead = sum[FRAC_W];

endmodule

// File: rtl/fp_mul_norm_round.sv
// Final stage of the single-precision multiplier: normalize the 48-bit
// significand product, round to nearest-even, and pack an IEEE-754 word with
// status flags. Two register stages with valid/ready on both sides;
// denormals are flushed to zero.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           upstream handshake
//   in_sign, in_exp, in_prod    sign, signed ea+eb-BIAS, significand product
//   in_is_nan/inf/zero          special-case classification from upstream
//   out_valid/out_ready         downstream handshake
//   out_result                  packed IEEE result
//   out_overflow/underflow/inexact status flags
module fp_mul_norm_round
  import fp_mul_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sign,
  input  logic signed [EXP_W+1:0]      in_exp,
  input  logic        [PROD_W-1:0]     in_prod,
  input  logic                         in_is_nan,
  input  logic                         in_is_inf,
  input  logic                         in_is_zero,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [RES_W-1:0]      out_result,
  output logic                         out_overflow,
  output logic                         out_underflow,
  output logic                         out_inexact
);

  s1_pay_t                  pay_p1_d, pay_p1_q;
  logic                     vld_p1_d, vld_p1_q;
  logic                     vld_p2_d, vld_p2_q;
  logic                     s2_load;
  logic [FRAC_W-1:0]        frac_p2;
  logic signed [XEXP_W-1:0] exp_p2;
  logic [RES_W-1:0]         res_d, res_q;
  logic                     ovf_d, ovf_q;
  logic                     unf_d, unf_q;
  logic                     inx_d, inx_q;

  // ---- stage 1: normalize ----
  always_comb begin
    pay_p1_d.sign    = in_sign;
    pay_p1_d.is_nan  = in_is_nan;
    pay_p1_d.is_inf  = in_is_inf;
    pay_p1_d.is_zero = in_is_zero;
    if (in_prod[PROD_W-1]) begin
      pay_p1_d.mant   = in_prod[PROD_W-1 -: FRAC_W+1];
      pay_p1_d.guard  = in_prod[FRAC_W];
      pay_p1_d.sticky = |in_prod[FRAC_W-1:0];
      pay_p1_d.exp    = in_exp + EXP_ONE;
    end else begin
      pay_p1_d.mant   = in_prod[PROD_W-2 -: FRAC_W+1];
      pay_p1_d.guard  = in_prod[FRAC_W-1];
      pay_p1_d.sticky = |in_prod[FRAC_W-2:0];
      pay_p1_d.exp    = in_exp;
    end
  end

  // Stage 2 refills whenever it is empty or being drained; stage 1 follows it.
  assign s2_load  = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || s2_load;
  assign vld_p1_d = in_ready ? in_valid : vld_p1_q;
  assign vld_p2_d = s2_load ? vld_p1_q : vld_p2_q;

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) pay_p1_q <= pay_p1_d;
  end

  // ---- stage 2: round and pack ----
  fp_round_ne u_round (
    .mant_i   (pay_p1_q.mant),
    .guard_i  (pay_p1_q.guard),
    .sticky_i (pay_p1_q.sticky),
    .exp_i    (pay_p1_q.exp),
    .frac_o   (frac_p2),
    .exp_o    (exp_p2)
  );

  always_comb begin
    res_d = {pay_p1_q.sign, exp_p2[EXP_W-1:0], frac_p2};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = pay_p1_q.guard | pay_p1_q.sticky;
    if (pay_p1_q.is_nan) begin
      res_d = QNAN;
      inx_d = 1'b0;
    end else if (pay_p1_q.is_inf) begin
      res_d = {pay_p1_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      inx_d = 1'b0;
    end else if (pay_p1_q.is_zero) begin
      res_d = {pay_p1_q.sign, {(RES_W - 1){1'b0}}};
      inx_d = 1'b0;
    end else if (exp_p2 >= EXP_MAX) begin
      res_d = {pay_p1_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (exp_p2 <= EXP_ZERO) begin
      res_d = {pay_p1_q.sign, {(RES_W - 1){1'b0}}};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      if (s2_load && vld_p1_q) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
        inx_q <= inx_d;
      end
    end
  end

  assign out_valid     = vld_p2_q;
  assign out_result    = res_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
  assign out_inexact   = inx_q;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
module tb_fp_mul_norm_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_prod;
  logic        in_is_nan, in_is_inf, in_is_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow, out_underflow, out_inexact;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        s;
    logic [9:0]  e;
    logic [47:0] p;
    logic        nan, inf, zero;
    logic [31:0] res;
    logic [2:0]  fl;   // {overflow, underflow, inexact}
  } vec_t;

  always #5 clk = ~clk;

  fp_mul_norm_round dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_prod       (in_prod),
    .in_is_nan     (in_is_nan),
    .in_is_inf     (in_is_inf),
    .in_is_zero    (in_is_zero),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] p,
                       input logic nan, input logic inf, input logic zero);
    in_sign    = s;
    in_exp     = e;
    in_prod    = p;
    in_is_nan  = nan;
    in_is_inf  = inf;
    in_is_zero = zero;
  endtask

  // One transfer with no backpressure; entered and left at posedge+1.
  task automatic run_one(input logic s, input logic [9:0] e, input logic [47:0] p,
                         input logic nan, input logic inf, input logic zero,
                         output logic [31:0] res, output logic [2:0] fl,
                         output logic vld0, output logic vld1);
    drive(s, e, p, nan, inf, zero);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vld0 = out_valid;
    @(posedge clk); #1;
    vld1 = out_valid;
    res  = out_result;
    fl   = {out_overflow, out_underflow, out_inexact};
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 10'd0, 48'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got %h want 00000000", out_result); end
    checks++;
    if ({out_overflow, out_underflow, out_inexact} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {out_overflow, out_underflow, out_inexact});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] res; logic [2:0] fl; logic v0, v1;
    run_one(1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, res, fl, v0, v1);
    checks++;
    if (v0 !== 1'b0) begin errors++; $display("FAIL basic_latency1 out_valid got %b want 0", v0); end
    checks++;
    if (v1 !== 1'b1) begin errors++; $display("FAIL basic_latency2 out_valid got %b want 1", v1); end
    checks++;
    if (res !== 32'h4010_0000) begin errors++; $display("FAIL basic_1p5x1p5 got %h want 40100000", res); end
    checks++;
    if (fl !== 3'b000) begin errors++; $display("FAIL basic_flags got %b want 000", fl); end
  endtask

  task automatic test_rounding();
    vec_t v[6];
    logic [31:0] res; logic [2:0] fl; logic v0, v1;
    v[0] = '{1'b0, 10'd127, 48'h4000_0040_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 3'b001}; // tie, even
    v[1] = '{1'b0, 10'd127, 48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0002, 3'b001}; // tie, odd
    v[2] = '{1'b0, 10'd127, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 3'b001}; // carry-out
    v[3] = '{1'b0, 10'd127, 48'h4000_0060_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0001, 3'b001}; // above half
    v[4] = '{1'b1, 10'd127, 48'h4000_0020_0000, 1'b0, 1'b0, 1'b0, 32'hBF80_0000, 3'b001}; // below half
    v[5] = '{1'b0, 10'd127, 48'h8000_0080_0000, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 3'b001}; // tie, top path
    for (int i = 0; i < 6; i++) begin
      run_one(v[i].s, v[i].e, v[i].p, v[i].nan, v[i].inf, v[i].zero, res, fl, v0, v1);
      checks++;
      if (v1 !== 1'b1) begin errors++; $display("FAIL round%0d_valid got %b want 1", i, v1); end
      checks++;
      if (res !== v[i].res) begin errors++; $display("FAIL round%0d_result got %h want %h", i, res, v[i].res); end
      checks++;
      if (fl !== v[i].fl) begin errors++; $display("FAIL round%0d_flags got %b want %b", i, fl, v[i].fl); end
    end
  endtask

  task automatic test_range_specials();
    vec_t v[11];
    logic [31:0] res; logic [2:0] fl; logic v0, v1;
    v[0]  = '{1'b0, 10'd254,  48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 3'b101}; // overflow
    v[1]  = '{1'b1, 10'd300,  48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'hFF80_0000, 3'b101}; // overflow neg
    v[2]  = '{1'b0, 10'd0,    48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b011}; // underflow
    v[3]  = '{1'b1, 10'h3FB,  48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 3'b011}; // exp -5
    v[4]  = '{1'b0, 10'd253,  48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h7F00_0000, 3'b000}; // max exp
    v[5]  = '{1'b0, 10'd1,    48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0080_0000, 3'b000}; // min normal
    v[6]  = '{1'b1, 10'd127,  48'h4000_0000_0000, 1'b1, 1'b0, 1'b0, 32'h7FC0_0000, 3'b000}; // nan
    v[7]  = '{1'b1, 10'd127,  48'h4000_0000_0000, 1'b0, 1'b1, 1'b0, 32'hFF80_0000, 3'b000}; // -inf
    v[8]  = '{1'b1, 10'd127,  48'h4000_0000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 3'b000}; // -0
    v[9]  = '{1'b0, 10'd127,  48'h4000_0000_0000, 1'b1, 1'b1, 1'b1, 32'h7FC0_0000, 3'b000}; // nan wins
    v[10] = '{1'b0, 10'd300,  48'h4000_0000_0000, 1'b0, 1'b1, 1'b1, 32'h7F80_0000, 3'b000}; // inf wins
    for (int i = 0; i < 11; i++) begin
      run_one(v[i].s, v[i].e, v[i].p, v[i].nan, v[i].inf, v[i].zero, res, fl, v0, v1);
      checks++;
      if (v1 !== 1'b1) begin errors++; $display("FAIL range%0d_valid got %b want 1", i, v1); end
      checks++;
      if (res !== v[i].res) begin errors++; $display("FAIL range%0d_result got %h want %h", i, res, v[i].res); end
      checks++;
      if (fl !== v[i].fl) begin errors++; $display("FAIL range%0d_flags got %b want %b", i, fl, v[i].fl); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expv[4];
    int          sent = 0;
    int          rcv = 0;
    logic        held = 1'b0;
    logic [31:0] held_val = '0;
    logic        acc;
    for (int k = 0; k < 4; k++) expv[k] = 32'h3F80_0000 + 32'(k + 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
      in_valid = (sent < 4);
      drive(1'b0, 10'd127, 48'h4000_0000_0000 | (48'(sent + 1) << 23), 1'b0, 1'b0, 1'b0);
      out_ready = (cyc >= 4);
      #1;
      if (held) begin
        checks++;
        if (out_result !== held_val || out_valid !== 1'b1) begin
          errors++; $display("FAIL b2b_hold cyc%0d got %h/%b want %h/1", cyc, out_result, out_valid, held_val);
        end
      end
      held     = out_valid && !out_ready;
      held_val = out_result;
      if (cyc == 2) begin
        checks++;
        if (in_ready !== 1'b0 || sent != 2) begin
          errors++; $display("FAIL b2b_in_ready got %b after %0d accepts want 0 after 2", in_ready, sent);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_result !== expv[rcv]) begin
          errors++; $display("FAIL b2b_order item%0d got %h want %h", rcv, out_result, expv[rcv]);
        end
        rcv++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if (rcv != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", rcv); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    logic [31:0] res; logic [2:0] fl; logic v0, v1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 10'd128, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL arst_full got valid %b ready %b want 1 0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_immediate out_valid got %b want 0", out_valid); end
    checks++;
    if (out_result !== 32'h0) begin errors++; $display("FAIL arst_result got %h want 00000000", out_result); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_no_escape out_valid got %b want 0", out_valid); end
    run_one(1'b1, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, res, fl, v0, v1);
    checks++;
    if (v0 !== 1'b0 || v1 !== 1'b1) begin
      errors++; $display("FAIL arst_latency got %b%b want 01", v0, v1);
    end
    checks++;
    if (res !== 32'hC010_0000) begin errors++; $display("FAIL arst_result_after got %h want c0100000", res); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_range_specials();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
